// File: rtl/timer_pkg.sv
// Shared definitions for the machine timer: register map and CTRL layout.
package timer_pkg;

    localparam int unsigned TIMER_DIV_W = 8;

    localparam logic [3:0] ADDR_MTIME_LO = 4'h0;
    localparam logic [3:0] ADDR_MTIME_HI = 4'h4;
    localparam logic [3:0] ADDR_CMP_LO   = 4'h8;
    localparam logic [3:0] ADDR_CMP_HI   = 4'hC;

    // div is declared first so that en lands in bit 0 of the packed CTRL word
    typedef struct packed {
        logic [TIMER_DIV_W-1:0] div;
        logic                   en;
    } timer_ctrl_t;

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider for mtime: emits a tick once every DIV+1 enabled cycles.
module timer_prescaler #(
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      en,
    input  logic [PRESCALE_WIDTH-1:0] div,
    input  logic                      clr,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] cnt_r;

    // A CTRL write restarts the divider, so it suppresses the tick of that cycle
    always_comb begin
        tick = en & ~clr & (cnt_r == div);
    end

    // Divider count; the +1 wraps modulo 2^PRESCALE_WIDTH
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= {PRESCALE_WIDTH{1'b0}};
        end else if (clr) begin
            cnt_r <= {PRESCALE_WIDTH{1'b0}};
        end else if (en) begin
            if (cnt_r == div) begin
                cnt_r <= {PRESCALE_WIDTH{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/machine_timer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp, prescaled increment,
// 32-bit register port with coherent hi/lo reads, and registered mtip.
module machine_timer
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALE_WIDTH = 8,
    parameter logic [63:0] CMP_RESET      = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    req,
    input  logic                    we,
    input  logic [3:0]              addr,
    input  logic [31:0]             wdata,
    input  logic                    ctrl_we,
    input  logic [PRESCALE_WIDTH:0] ctrl_wd,
    output logic [31:0]             rdata,
    output logic                    ack,
    output logic                    tick,
    output logic                    mtip
);

    logic                      en_r;
    logic [PRESCALE_WIDTH-1:0] div_r;
    logic [63:0]               mtime_r;
    logic [63:0]               cmp_r;
    logic [31:0]               hi_snap_r;

    logic                      tick_s;
    logic                      wr_s;
    logic                      rd_s;
    logic                      mtime_wr_s;
    logic [63:0]               mtime_inc_s;
    logic [63:0]               mtime_nxt_s;
    logic [63:0]               cmp_nxt_s;
    logic [31:0]               rdata_s;

    timer_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk  (clk),
        .rstn (rstn),
        .en   (en_r),
        .div  (div_r),
        .clr  (ctrl_we),
        .tick (tick_s)
    );

    // Next-state for mtime/mtimecmp; a half-write keeps the other half of mtime+tick
    always_comb begin
        wr_s        = req & we;
        rd_s        = req & ~we;
        mtime_inc_s = mtime_r + {63'd0, tick_s};
        mtime_nxt_s = mtime_inc_s;
        mtime_wr_s  = 1'b0;
        cmp_nxt_s   = cmp_r;
        if (wr_s) begin
            case (addr)
                ADDR_MTIME_LO: begin
                    mtime_nxt_s = {mtime_inc_s[63:32], wdata};
                    mtime_wr_s  = 1'b1;
                end
                ADDR_MTIME_HI: begin
                    mtime_nxt_s = {wdata, mtime_inc_s[31:0]};
                    mtime_wr_s  = 1'b1;
                end
                ADDR_CMP_LO: cmp_nxt_s = {cmp_r[63:32], wdata};
                ADDR_CMP_HI: cmp_nxt_s = {wdata, cmp_r[31:0]};
                default:     cmp_nxt_s = cmp_r;
            endcase
        end else begin
            cmp_nxt_s = cmp_r;
        end
    end

    // Read mux; MTIME_HI returns the snapshot taken by the last MTIME_LO read
    always_comb begin
        rdata_s = 32'd0;
        if (rd_s) begin
            case (addr)
                ADDR_MTIME_LO: rdata_s = mtime_r[31:0];
                ADDR_MTIME_HI: rdata_s = hi_snap_r;
                ADDR_CMP_LO:   rdata_s = cmp_r[31:0];
                ADDR_CMP_HI:   rdata_s = cmp_r[63:32];
                default:       rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    // Architectural state and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_r      <= 1'b0;
            div_r     <= {PRESCALE_WIDTH{1'b0}};
            mtime_r   <= 64'd0;
            cmp_r     <= CMP_RESET;
            hi_snap_r <= 32'd0;
            rdata     <= 32'd0;
            ack       <= 1'b0;
            tick      <= 1'b0;
            mtip      <= 1'b0;
        end else begin
            if (ctrl_we) begin
                en_r  <= ctrl_wd[0];
                div_r <= ctrl_wd[PRESCALE_WIDTH:1];
            end else begin
                en_r  <= en_r;
                div_r <= div_r;
            end
            if (rd_s && (addr == ADDR_MTIME_LO)) begin
                hi_snap_r <= mtime_r[63:32];
            end else begin
                hi_snap_r <= hi_snap_r;
            end
            mtime_r <= mtime_nxt_s;
            cmp_r   <= cmp_nxt_s;
            rdata   <= rdata_s;
            ack     <= req;
            tick    <= tick_s & ~mtime_wr_s;
            mtip    <= (mtime_r >= cmp_r);
        end
    end

endmodule
